fpmul_rr_sched: RTL and testbench
=================================

Name: fpmul_rr_sched

Overview:
- Round-robin scheduler that shares one three-operand floating point multiplier pipeline (r = a*b*c, 64-bit operands, fixed latency, pushin/pushout, no backpressure) among NREQ requesters.
- Arbitrates issue slots and registers the operands into the multiplier.
- Tags each issue with its requester ID and routes each pushout result back to the owning requester.
- Sits between the requester-side operand queues and the multiplier instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must equal clog2(NREQ).
- LAT, 11, multiplier latency in cycles from pushin to pushout.
- MAX_OUT, 8, per-requester cap on in-flight operations (1..LAT+1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-low.
- req_valid  in  NREQ  requester i has an operand triple.
- req_a  in  64*NREQ  operand a; slice i at [64*i+63:64*i]. Same slicing for req_b and req_c.
- req_b  in  64*NREQ  operand b.
- req_c  in  64*NREQ  operand c.
- req_ready  out  NREQ  one-hot grant; transfer occurs when req_valid[i] & req_ready[i].
- mul_pushin  out  1  registered issue strobe to the multiplier.
- mul_a  out  64  registered operand a to the multiplier.
- mul_b  out  64  registered operand b to the multiplier.
- mul_c  out  64  registered operand c to the multiplier.
- mul_pushout  in  1  multiplier result valid.
- mul_r  in  64  multiplier result.
- rsp_valid  out  NREQ  one-hot; result for requester i valid this cycle.
- rsp_r  out  64  registered result, shared by all requesters.
- rsp_id  out  IDW  ID of the current response.
- sched_err  out  1  sticky error: pushout/tag mismatch.

Behaviour:
- Reset (rst low, async): mul_pushin=0, mul_a/b/c=0, rsp_valid=0, rsp_r=0, rsp_id=0, sched_err=0, all outstanding counters=0, tag pipeline cleared, rr pointer=0. req_ready=0 while in reset.
- Eligibility: eligible[i] = req_valid[i] & (outstanding[i] < MAX_OUT).
- Grant (combinational from registered state): search eligible starting at index ptr and wrapping NREQ-1 -> 0. The first hit gets req_ready. At most one grant per cycle; none if no requester is eligible.
- Pointer: on a grant to i, ptr <= (i+1) mod NREQ. With no grant, ptr holds.
- Issue: on a grant, next edge sets mul_pushin=1 and mul_a/b/c = the granted slices. Otherwise mul_pushin=0 and operands hold their previous values.
- Tag pipeline: LAT-stage shift of {valid, id}. Stage 0 loads {mul_pushin, issued id} on the edge that registers the issue. The tail aligns with mul_pushout.
- Response: on mul_pushout=1, next edge sets:
  - rsp_valid one-hot at the tail id,
  - rsp_r = mul_r,
  - rsp_id = tail id.
  Otherwise rsp_valid=0; rsp_r and rsp_id hold.
- Latency: grant cycle to rsp_valid = LAT+2 cycles (13 at default). Sustained throughput is one result per cycle.
- Outstanding[i]: +1 on grant to i, -1 on response to i. Both in the same cycle leaves it unchanged. Saturation cannot occur because of the MAX_OUT gate.
- Mismatch: if mul_pushout differs from the tail valid, set sched_err=1 (held until reset). If mul_pushout=1 and the tail is invalid, rsp_valid stays 0 and no counter changes.
- Requesters have no backpressure on responses; a consumer must accept rsp_valid in the same cycle.
- Reset mid-operation: in-flight tags and counters are discarded. The multiplier must be reset in the same cycle.

Optional Feature:
- Macro FPMUL_RR_SCHED_STATS_EN.
- Defined: adds outputs stat_grants (32*NREQ, per-requester grant counts) and stat_stall (32, cycles with any req_valid=1 but no grant). Both wrap at 2^32 and reset to 0.
- Not defined: these ports and their counters are absent; all other behaviour is identical.

Test Plan:
- Single requester: req_valid=4'b0001, a=2.0 (0x4000000000000000), b=3.0, c=0.5; stub multiplier LAT=11 -> req_ready[0] at cycle 0, mul_pushin at cycle 1, rsp_valid=4'b0001 with rsp_r=3.0 (0x4008000000000000) at cycle 13.
- All four requesters hold valid for 8 cycles from ptr=0 -> grants 0,1,2,3,0,1,2,3; responses return in the same order with matching rsp_id.
- MAX_OUT=2, only requester 2 valid continuously -> grants at cycles 0 and 1 only. Next grant in the cycle after the first response frees a slot; outstanding[2] never exceeds 2.
- Grant to requester 1 and response to requester 1 in the same cycle -> outstanding[1] unchanged.
- Stub injects mul_pushout with an empty tail -> sched_err=1 and stays 1; rsp_valid stays 0.
- Assert rst low mid-stream with 5 operations in flight -> all outputs 0 within the reset cycle. After release, the first grant goes to requester 0 and no stale responses appear.

Source files
------------

// File: rtl/fpmul_rr_sched.sv
// Round-robin issue scheduler that shares one fixed-latency a*b*c multiplier among NREQ requesters.
// Optional statistics counters are enabled by defining FPMUL_RR_SCHED_STATS_EN.
module fpmul_rr_sched #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int LAT     = 11,
    parameter int MAX_OUT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [64*NREQ-1:0]   req_a,
    input  logic [64*NREQ-1:0]   req_b,
    input  logic [64*NREQ-1:0]   req_c,
    output logic [NREQ-1:0]      req_ready,
    output logic                 mul_pushin,
    output logic [63:0]          mul_a,
    output logic [63:0]          mul_b,
    output logic [63:0]          mul_c,
    input  logic                 mul_pushout,
    input  logic [63:0]          mul_r,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [63:0]          rsp_r,
    output logic [IDW-1:0]       rsp_id,
`ifdef FPMUL_RR_SCHED_STATS_EN
    output logic [32*NREQ-1:0]   stat_grants,
    output logic [31:0]          stat_stall,
`endif
    output logic                 sched_err
);

    // Handshake: an operand triple moves when req_valid[i] and req_ready[i] are both high
    // in the same cycle. req_ready is a one-hot grant derived from registered state and
    // req_valid only; responses carry no backpressure and must be taken when rsp_valid is high.

    localparam int CW = $clog2(MAX_OUT + 1);

    logic [IDW-1:0]  ptr;
    logic [CW-1:0]   outstanding [NREQ];
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic            grant_any;
    logic [63:0]     sel_a, sel_b, sel_c;
    logic [IDW-1:0]  iss_id;
    logic [LAT-1:0]  tag_v;
    logic [IDW-1:0]  tag_id [LAT];
    logic            tail_v;
    logic [IDW-1:0]  tail_id;

    assign tail_v  = tag_v[LAT-1];
    assign tail_id = tag_id[LAT-1];

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = req_valid[i] && (outstanding[i] < CW'(MAX_OUT));
        end
    end

    // Rotating priority search starting at ptr, wrapping past NREQ-1 back to 0.
    always_comb begin
        logic [IDW-1:0] idx;
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (!grant_any && eligible[idx]) begin
                grant_any   = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = idx;
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        sel_c = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[64*i +: 64];
                sel_b = req_b[64*i +: 64];
                sel_c = req_c[64*i +: 64];
            end
        end
    end

    assign req_ready = rst ? grant : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr        <= '0;
            mul_pushin <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_c      <= '0;
            iss_id     <= '0;
            tag_v      <= '0;
            rsp_valid  <= '0;
            rsp_r      <= '0;
            rsp_id     <= '0;
            sched_err  <= 1'b0;
            for (int s = 0; s < LAT; s++) begin
                tag_id[s] <= '0;
            end
            for (int i = 0; i < NREQ; i++) begin
                outstanding[i] <= '0;
            end
        end else begin
            mul_pushin <= grant_any;
            if (grant_any) begin
                mul_a  <= sel_a;
                mul_b  <= sel_b;
                mul_c  <= sel_c;
                iss_id <= grant_id;
                ptr    <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
            end

            // Tag stage 0 follows the multiplier input register so the tail meets mul_pushout.
            tag_v     <= {tag_v[LAT-2:0], mul_pushin};
            tag_id[0] <= iss_id;
            for (int s = 1; s < LAT; s++) begin
                tag_id[s] <= tag_id[s-1];
            end

            for (int i = 0; i < NREQ; i++) begin
                rsp_valid[i] <= mul_pushout && tail_v && (tail_id == IDW'(i));
            end
            if (mul_pushout && tail_v) begin
                rsp_r  <= mul_r;
                rsp_id <= tail_id;
            end

            if (mul_pushout != tail_v) begin
                sched_err <= 1'b1;
            end

            // A slot frees when the registered response is presented to its owner.
            for (int i = 0; i < NREQ; i++) begin
                if (grant[i] && !rsp_valid[i]) begin
                    outstanding[i] <= outstanding[i] + CW'(1);
                end else if (!grant[i] && rsp_valid[i]) begin
                    outstanding[i] <= outstanding[i] - CW'(1);
                end
            end
        end
    end

`ifdef FPMUL_RR_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_grants <= '0;
            stat_stall  <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant[i]) begin
                    stat_grants[32*i +: 32] <= stat_grants[32*i +: 32] + 32'd1;
                end
            end
            if ((|req_valid) && !grant_any) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fpmul_rr_sched.sv
// Self-checking bench for fpmul_rr_sched: stub a*b*c multiplier, scoreboard of expected responses,
// and one task per scenario.
module tb_fpmul_rr_sched;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int LAT     = 11;
    localparam int MAX_OUT = 2;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [64*NREQ-1:0]  req_a, req_b, req_c;
    logic [NREQ-1:0]     req_ready;
    logic                mul_pushin;
    logic [63:0]         mul_a, mul_b, mul_c;
    logic                mul_pushout;
    logic [63:0]         mul_r;
    logic [NREQ-1:0]     rsp_valid;
    logic [63:0]         rsp_r;
    logic [IDW-1:0]      rsp_id;
    logic                sched_err;
    logic                inj;

    int checks = 0;
    int errors = 0;
    logic [IDW+63:0] exp_q[$];
    int out_m [NREQ];

    fpmul_rr_sched #(.NREQ(NREQ), .IDW(IDW), .LAT(LAT), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .req_ready(req_ready),
        .mul_pushin(mul_pushin), .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
        .mul_pushout(mul_pushout), .mul_r(mul_r),
        .rsp_valid(rsp_valid), .rsp_r(rsp_r), .rsp_id(rsp_id),
        .sched_err(sched_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] fmul3(input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] c);
        return $realtobits($bitstoreal(a) * $bitstoreal(b) * $bitstoreal(c));
    endfunction

    // ---------------- stub multiplier, latency LAT ----------------
    logic [LAT-1:0] sp_v;
    logic [63:0]    sp_r [LAT];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_v <= '0;
            for (int k = 0; k < LAT; k++) sp_r[k] <= '0;
        end else begin
            sp_v    <= {sp_v[LAT-2:0], mul_pushin};
            sp_r[0] <= fmul3(mul_a, mul_b, mul_c);
            for (int k = 1; k < LAT; k++) sp_r[k] <= sp_r[k-1];
        end
    end

    assign mul_pushout = sp_v[LAT-1] | inj;
    assign mul_r       = sp_r[LAT-1];

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_q.push_back({IDW'(i), fmul3(req_a[64*i +: 64], req_b[64*i +: 64],
                                                   req_c[64*i +: 64])});
                    out_m[i]++;
                    checks++;
                    if (out_m[i] > MAX_OUT) begin
                        errors++;
                        $display("FAIL outstanding_cap: req %0d has %0d in flight, limit %0d",
                                 i, out_m[i], MAX_OUT);
                    end
                end
            end
            if (rsp_valid != '0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rsp: rsp_valid=%b id=%0d r=%h, none expected",
                             rsp_valid, rsp_id, rsp_r);
                end else begin
                    logic [IDW+63:0] e;
                    logic [NREQ-1:0] oh;
                    e  = exp_q.pop_front();
                    oh = '0;
                    oh[e[IDW+63:64]] = 1'b1;
                    out_m[e[IDW+63:64]]--;
                    if (rsp_valid !== oh || rsp_id !== e[IDW+63:64] || rsp_r !== e[63:0]) begin
                        errors++;
                        $display("FAIL rsp_data: got valid=%b id=%0d r=%h, expected valid=%b id=%0d r=%h",
                                 rsp_valid, rsp_id, rsp_r, oh, e[IDW+63:64], e[63:0]);
                    end
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic do_reset();
        rst       = 1'b0;
        req_valid = '0;
        inj       = 1'b0;
        repeat (2) @(posedge clk);
        exp_q.delete();
        for (int i = 0; i < NREQ; i++) out_m[i] = 0;
        #1 rst = 1'b1;
    endtask

    task automatic rand_operands();
        for (int i = 0; i < NREQ; i++) begin
            req_a[64*i +: 64] = $realtobits(real'($urandom_range(1, 64)));
            req_b[64*i +: 64] = $realtobits(real'($urandom_range(1, 64)));
            req_c[64*i +: 64] = $realtobits(0.5);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst       = 1'b0;
        inj       = 1'b0;
        req_valid = '1;
        rand_operands();
        #3;
        checks++;
        if (req_ready !== '0 || mul_pushin !== 1'b0 || mul_a !== '0 || mul_b !== '0 ||
            mul_c !== '0 || rsp_valid !== '0 || rsp_r !== '0 || rsp_id !== '0 ||
            sched_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b pushin=%b a=%h rsp_valid=%b r=%h id=%0d err=%b, all required 0",
                     req_ready, mul_pushin, mul_a, rsp_valid, rsp_r, rsp_id, sched_err);
        end
        do_reset();
    endtask

    task automatic test_single();
        int lat;
        do_reset();
        @(posedge clk); #1;
        req_a = '0; req_b = '0; req_c = '0;
        req_a[63:0] = 64'h4000000000000000;
        req_b[63:0] = 64'h4008000000000000;
        req_c[63:0] = 64'h3FE0000000000000;
        req_valid   = 4'b0001;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_grant: req_ready=%b, expected 0001", req_ready);
        end
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (mul_pushin !== 1'b1 || mul_a !== 64'h4000000000000000 || mul_b !== 64'h4008000000000000 ||
            mul_c !== 64'h3FE0000000000000) begin
            errors++;
            $display("FAIL single_issue: pushin=%b a=%h b=%h c=%h", mul_pushin, mul_a, mul_b, mul_c);
        end
        lat = 1;
        while (rsp_valid == '0 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 13 || rsp_valid !== 4'b0001 || rsp_r !== 64'h4008000000000000 || rsp_id !== 2'd0) begin
            errors++;
            $display("FAIL single_latency: cycle=%0d valid=%b r=%h id=%0d, expected cycle 13 valid 0001 r=4008000000000000 id 0",
                     lat, rsp_valid, rsp_r, rsp_id);
        end
    endtask

    task automatic test_round_robin();
        int n;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            req_valid = '1;
            rand_operands();
            @(negedge clk);
            checks++;
            if (req_ready !== 4'(1 << (k % NREQ))) begin
                errors++;
                $display("FAIL rr_grant: cycle %0d req_ready=%b, expected %b", k, req_ready,
                         4'(1 << (k % NREQ)));
            end
        end
        @(posedge clk); #1;
        req_valid = '0;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rr_drain: %0d responses missing, expected 0", exp_q.size());
        end
    endtask

    task automatic test_max_out();
        int n;
        logic [NREQ-1:0] exp_rdy;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            req_valid = 4'b0100;
            rand_operands();
            @(negedge clk);
            exp_rdy = (k == 0 || k == 1 || k == 14 || k == 15) ? 4'b0100 : 4'b0000;
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL maxout_grant: cycle %0d req_ready=%b, expected %b", k, req_ready, exp_rdy);
            end
        end
        @(posedge clk); #1;
        req_valid = '0;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL maxout_drain: %0d responses missing, expected 0", exp_q.size());
        end
    endtask

    // Cycle 14 grants requester 1 while its first response is presented: count must hold at 1.
    task automatic test_same_cycle();
        int n;
        logic [NREQ-1:0] exp_rdy;
        do_reset();
        for (int k = 0; k < 17; k++) begin
            @(posedge clk); #1;
            req_valid = (k < 2 || k >= 14) ? 4'b0010 : 4'b0000;
            rand_operands();
            @(negedge clk);
            exp_rdy = (k < 2 || k == 14 || k == 15) ? 4'b0010 : 4'b0000;
            if (k == 14) begin
                checks++;
                if (rsp_valid !== 4'b0010) begin
                    errors++;
                    $display("FAIL same_cycle_rsp: cycle 14 rsp_valid=%b, expected 0010", rsp_valid);
                end
            end
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL same_cycle_grant: cycle %0d req_ready=%b, expected %b", k, req_ready, exp_rdy);
            end
        end
        @(posedge clk); #1;
        req_valid = '0;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL same_cycle_drain: %0d responses missing, expected 0", exp_q.size());
        end
    endtask

    task automatic test_err();
        do_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (sched_err !== 1'b0) begin
            errors++;
            $display("FAIL err_idle: sched_err=%b, expected 0", sched_err);
        end
        @(posedge clk); #1;
        inj = 1'b1;
        @(posedge clk); #1;
        inj = 1'b0;
        @(negedge clk);
        checks++;
        if (sched_err !== 1'b1 || rsp_valid !== '0) begin
            errors++;
            $display("FAIL err_set: sched_err=%b rsp_valid=%b, expected 1 and 0000", sched_err, rsp_valid);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (sched_err !== 1'b1 || rsp_valid !== '0) begin
            errors++;
            $display("FAIL err_sticky: sched_err=%b rsp_valid=%b, expected 1 and 0000", sched_err, rsp_valid);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            req_valid = '1;
            rand_operands();
        end
        @(posedge clk); #1;
        req_valid = '0;
        repeat (3) @(posedge clk);
        #2;
        req_valid = '1;
        rst       = 1'b0;
        #1;
        exp_q.delete();
        for (int i = 0; i < NREQ; i++) out_m[i] = 0;
        checks++;
        if (req_ready !== '0 || mul_pushin !== 1'b0 || mul_a !== '0 || mul_b !== '0 ||
            mul_c !== '0 || rsp_valid !== '0 || rsp_r !== '0 || rsp_id !== '0 ||
            sched_err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: ready=%b pushin=%b a=%h rsp_valid=%b r=%h id=%0d err=%b, all required 0",
                     req_ready, mul_pushin, mul_a, rsp_valid, rsp_r, rsp_id, sched_err);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL midreset_first_grant: req_ready=%b, expected 0001", req_ready);
        end
        @(posedge clk); #1;
        req_valid = '0;
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (rsp_valid != '0) pulses++;
        end
        checks++;
        if (pulses != 1 || sched_err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_stale: %0d responses sched_err=%b, expected 1 response and 0",
                     pulses, sched_err);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        req_valid = '0;
        req_a = '0; req_b = '0; req_c = '0;
        inj = 1'b0;
        rst = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_max_out();
        test_same_cycle();
        test_err();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
